joy_db15_tx: RTL and testbench

Device-side model of the serial DB15 SNAC joystick adapter: it answers the load/clock strobes produced by the `joy_db15` host-side reader and shifts out the button states of two joysticks on a single data line. The block acts as a 74HC165-style parallel-load shift register with input synchronisation, edge detection and framing status. It sits behind the USER port pins in loopback and verification builds, and in the standalone adapter-emulation core.

---
 rtl/joy_db15_pkg.sv | 27 ++
 rtl/joy_db15_tx_sync_edge.sv | 46 ++++
 rtl/joy_db15_tx.sv | 80 ++++++++
 tb/tb_joy_db15_tx.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_db15_pkg.sv
// Shared constants for the DB15 SNAC joystick serial link.
package joy_db15_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam logic        IDLE_LEVEL = 1'b1;

  // Button bit positions within a 16-bit joystick word (LSFEDCBAUDLR).
  localparam int unsigned JOY_RIGHT  = 0;
  localparam int unsigned JOY_LEFT   = 1;
  localparam int unsigned JOY_DOWN   = 2;
  localparam int unsigned JOY_UP     = 3;
  localparam int unsigned JOY_A      = 4;
  localparam int unsigned JOY_B      = 5;
  localparam int unsigned JOY_C      = 6;
  localparam int unsigned JOY_D      = 7;
  localparam int unsigned JOY_E      = 8;
  localparam int unsigned JOY_F      = 9;
  localparam int unsigned JOY_START  = 10;
  localparam int unsigned JOY_SELECT = 11;

  // Line image of both joysticks: active-low, bit 0 leaves first.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [15:0] j1,
                                                       input logic [15:0] j2);
    return ~{j2, j1};
  endfunction

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Multi-stage synchroniser with registered rise/fall pulses; idles high.
module sync_edge
  import joy_db15_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; the pin enters at bit 0.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Registered edge detector; level is taken from the same stage so it
  // lines up with the rise/fall pulses.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      prev_q <= IDLE_LEVEL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      prev_q <= sync_out;
      rise   <= sync_out & ~prev_q;
      fall   <= ~sync_out & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick shifter: 74HC165-style load/shift with framing status.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic        frame_done,
  output logic        short_frame
);

  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_LAST = 6'(FRAME_BITS - 1);

  logic                  clk_level, clk_rise, clk_fall;
  logic                  load_s, load_rise, load_fall;
  logic [FRAME_BITS-1:0] shift_q;
  logic [5:0]            bit_cnt;
  logic                  unused_edges;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .din     (joy_clk),
    .level   (clk_level),
    .rise    (clk_rise),
    .fall    (clk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .din     (joy_load),
    .level   (load_s),
    .rise    (load_rise),
    .fall    (load_fall)
  );

  // Falling shift-clock edges and the load release carry no action.
  assign unused_edges = &{1'b0, clk_level, clk_fall, load_rise};

  // Load takes priority over a coincident shift edge; short_frame looks at
  // the count before the load clears it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      shift_q     <= '1;
      bit_cnt     <= CNT_FULL;
      joy_data    <= IDLE_LEVEL;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      if (!load_s) begin
        shift_q  <= frame_word(joystick1, joystick2);
        bit_cnt  <= '0;
        joy_data <= ~joystick1[0];
        if (load_fall && (bit_cnt != '0) && (bit_cnt != CNT_FULL)) begin
          short_frame <= 1'b1;
        end
      end else if (clk_rise) begin
        shift_q  <= {IDLE_LEVEL, shift_q[FRAME_BITS-1:1]};
        joy_data <= shift_q[1];
        if (bit_cnt != CNT_FULL) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
        if (bit_cnt == CNT_LAST) begin
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
`timescale 1ns/1ps
module tb_joy_db15_tx;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] joystick1 = '0;
  logic [15:0] joystick2 = '0;
  logic        joy_clk = 1'b1;
  logic        joy_load = 1'b1;
  logic        joy_data;
  logic        frame_done;
  logic        short_frame;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int sf_cnt = 0;
  int fd_cyc = -1;

  joy_db15_tx #(.SYNC_STAGES(2)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .joy_clk     (joy_clk),
    .joy_load    (joy_load),
    .joy_data    (joy_data),
    .frame_done  (frame_done),
    .short_frame (short_frame)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Pulse monitor: a pulse wider than one cycle counts more than once.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (frame_done) begin
        fd_cnt = fd_cnt + 1;
        fd_cyc = cyc;
      end
      if (short_frame) sf_cnt = sf_cnt + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic load_pulse(input int n);
    joy_load = 1'b0;
    wait_cyc(n);
    joy_load = 1'b1;
    wait_cyc(8);
  endtask

  // bits[0] is the level after load, bits[k] the level after rise k.
  task automatic clocks(input int n, output logic [63:0] bits, output int r32);
    bits = '1;
    r32 = -1;
    bits[0] = joy_data;
    for (int k = 1; k <= n; k++) begin
      joy_clk = 1'b1;
      if (k == 32) r32 = cyc;
      wait_cyc(8);
      joy_clk = 1'b0;
      wait_cyc(8);
      bits[k] = joy_data;
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    joy_clk = 1'b1;
    joy_load = 1'b1;
    wait_cyc(3);
    checks++;
    if ({joy_data, frame_done, short_frame} !== 3'b100) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 100", {joy_data, frame_done, short_frame});
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      wait_cyc(1);
      if ({joy_data, frame_done, short_frame} !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d cycles off idle, expected 0", bad);
    end
    joy_clk = 1'b0;
    wait_cyc(8);
  endtask

  task automatic test_full_frame();
    logic [63:0] bits;
    int r32, fd0, sf0;
    joystick1 = 16'h0011;
    joystick2 = 16'h8000;
    fd0 = fd_cnt;
    sf0 = sf_cnt;
    load_pulse(10);
    clocks(32, bits, r32);
    checks++;
    if (bits[31:0] !== 32'h7FFF_FFEE) begin
      errors++;
      $display("FAIL full_stream: got %h expected 7fffffee", bits[31:0]);
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL full_done_count: got %0d expected 1", fd_cnt - fd0);
    end
    checks++;
    if (fd_cyc != r32 + 4) begin
      errors++;
      $display("FAIL full_done_latency: got %0d expected %0d", fd_cyc - r32, 4);
    end
    checks++;
    if (sf_cnt != sf0) begin
      errors++;
      $display("FAIL full_no_short: got %0d pulses expected 0", sf_cnt - sf0);
    end
  endtask

  task automatic test_overclock();
    logic [63:0] bits;
    int r32, fd0;
    joystick1 = 16'h0011;
    joystick2 = 16'h8000;
    fd0 = fd_cnt;
    load_pulse(10);
    clocks(40, bits, r32);
    checks++;
    if (bits[31:0] !== 32'h7FFF_FFEE) begin
      errors++;
      $display("FAIL over_stream: got %h expected 7fffffee", bits[31:0]);
    end
    checks++;
    if (bits[40:32] !== 9'h1FF) begin
      errors++;
      $display("FAIL over_tail: got %b expected 111111111", bits[40:32]);
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL over_done_count: got %0d expected 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_short_frame();
    logic [63:0] bits;
    int r32, sf0;
    joystick1 = 16'h0A5B;
    joystick2 = 16'h1234;
    // Previous frame ran to completion: no pulse.
    sf0 = sf_cnt;
    load_pulse(10);
    checks++;
    if (sf_cnt != sf0) begin
      errors++;
      $display("FAIL short_after_full: got %0d pulses expected 0", sf_cnt - sf0);
    end
    // One bit shifted.
    clocks(1, bits, r32);
    sf0 = sf_cnt;
    load_pulse(10);
    checks++;
    if (sf_cnt - sf0 != 1) begin
      errors++;
      $display("FAIL short_after_1: got %0d pulses expected 1", sf_cnt - sf0);
    end
    // 31 bits shifted, one short of a frame.
    clocks(31, bits, r32);
    sf0 = sf_cnt;
    load_pulse(10);
    checks++;
    if (sf_cnt - sf0 != 1) begin
      errors++;
      $display("FAIL short_after_31: got %0d pulses expected 1", sf_cnt - sf0);
    end
    clocks(10, bits, r32);
    sf0 = sf_cnt;
    load_pulse(10);
    checks++;
    if (sf_cnt - sf0 != 1) begin
      errors++;
      $display("FAIL short_after_10: got %0d pulses expected 1", sf_cnt - sf0);
    end
    checks++;
    if (joy_data !== 1'b0) begin
      errors++;
      $display("FAIL short_first_bit: got %b expected 0", joy_data);
    end
    // Zero bits shifted: no pulse.
    sf0 = sf_cnt;
    load_pulse(10);
    checks++;
    if (sf_cnt != sf0) begin
      errors++;
      $display("FAIL short_after_0: got %0d pulses expected 0", sf_cnt - sf0);
    end
    clocks(32, bits, r32);
    checks++;
    if (bits[31:0] !== 32'hEDCB_F5A4) begin
      errors++;
      $display("FAIL short_restream: got %h expected edcbf5a4", bits[31:0]);
    end
  endtask

  task automatic test_load_vs_clock();
    logic [63:0] bits;
    int r32, sf0;
    joystick1 = 16'h0021;
    joystick2 = 16'h0000;
    load_pulse(10);
    clocks(5, bits, r32);
    checks++;
    if (joy_data !== 1'b0) begin
      errors++;
      $display("FAIL lvc_pre_bit5: got %b expected 0", joy_data);
    end
    sf0 = sf_cnt;
    joy_clk = 1'b1;
    joy_load = 1'b0;
    wait_cyc(4);
    checks++;
    if (joy_data !== 1'b0) begin
      errors++;
      $display("FAIL lvc_load_wins: got %b expected 0", joy_data);
    end
    wait_cyc(4);
    joy_clk = 1'b0;
    wait_cyc(8);
    checks++;
    if (sf_cnt - sf0 != 1) begin
      errors++;
      $display("FAIL lvc_short_precount: got %0d pulses expected 1", sf_cnt - sf0);
    end
    // Clock rise together with load release is a real shift.
    joy_load = 1'b1;
    joy_clk = 1'b1;
    wait_cyc(8);
    checks++;
    if (joy_data !== 1'b1) begin
      errors++;
      $display("FAIL lvc_release_shift: got %b expected 1", joy_data);
    end
    joy_clk = 1'b0;
    wait_cyc(8);
    clocks(31, bits, r32);
    checks++;
    if (bits[30:0] !== 31'h7FFF_FFEF) begin
      errors++;
      $display("FAIL lvc_rest_stream: got %h expected 7fffffef", bits[30:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] bits;
    int r32, sf0, fd0;
    joystick1 = 16'h00E1;
    joystick2 = 16'h5A00;
    load_pulse(10);
    clocks(5, bits, r32);
    checks++;
    if (joy_data !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_bit5: got %b expected 0", joy_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (joy_data !== 1'b1) begin
      errors++;
      $display("FAIL mid_async_reset: got %b expected 1", joy_data);
    end
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(8);
    sf0 = sf_cnt;
    fd0 = fd_cnt;
    load_pulse(10);
    checks++;
    if (sf_cnt != sf0) begin
      errors++;
      $display("FAIL mid_no_short: got %0d pulses expected 0", sf_cnt - sf0);
    end
    clocks(32, bits, r32);
    checks++;
    if (bits[31:0] !== 32'hA5FF_FF1E) begin
      errors++;
      $display("FAIL mid_stream: got %h expected a5ffff1e", bits[31:0]);
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL mid_done_count: got %0d expected 1", fd_cnt - fd0);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overclock();
    test_short_frame();
    test_load_vs_clock();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
